pipelined_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor. It replaces the fixed 4-bit ripple adder in the arithmetic datapath. The WIDTH-bit add is split into STAGES equal slices, and a register sits on the carry between consecutive slices, so one operation can be accepted per cycle at any width. The block has valid/ready handshakes on both sides, a subtract mode, and carry-out and signed-overflow flags.

---
 rtl/pipelined_adder_pkg.sv | 9 +
 rtl/pipelined_adder_slice.sv | 31 +++
 rtl/pipelined_adder.sv | 147 ++++++++++++++
 tb/tb_pipelined_adder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared defaults for the pipelined adder/subtractor datapath.
`timescale 1ns/1ps
package pipelined_adder_pkg;

  // Default geometry: 16-bit word cut into four 4-bit carry slices.
  localparam int PA_DEF_WIDTH  = 16;
  localparam int PA_DEF_STAGES = 4;

endpackage

// File: rtl/pipelined_adder_slice.sv
// adder_slice: purely combinational CHUNK-bit ripple-carry adder.
// Also exposes the carry into its MSB so the top slice can form signed overflow.
`timescale 1ns/1ps
module adder_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  // Bit-serial ripple: each bit's carry feeds the next bit in the slice.
  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder/subtractor split into STAGES ripple slices
// with a register on the carry between slices. Operand bits for slice k are
// skewed k stages to meet their carry; finished result bits are deskewed so
// the whole word leaves aligned. One global enable stalls every register.
`timescale 1ns/1ps
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = PA_DEF_WIDTH,
  parameter int STAGES = PA_DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             w_en;
  logic [WIDTH-1:0] w_b_mod;
  logic             w_cin0;

  // A slot may advance whenever the output register is empty or being drained.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Subtract is a + ~b + 1: invert B and force the slice-0 carry-in.
  assign w_b_mod = sub ? ~b : b;
  assign w_cin0  = sub ? 1'b1 : c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int SUMW = (k + 1) * CHUNK;
    localparam int REMW = WIDTH - SUMW;

    logic [CHUNK-1:0] w_op_a;
    logic [CHUNK-1:0] w_op_b;
    logic [CHUNK-1:0] w_s;
    logic             w_ci;
    logic             w_co;
    logic             w_cm;
    logic             w_vld_in;
    logic [SUMW-1:0]  w_sum_in;

    logic             r_vld_p;
    logic [SUMW-1:0]  r_sum_p;
    logic             r_c_p;

    if (k == 0) begin : g_head
      assign w_op_a   = a[CHUNK-1:0];
      assign w_op_b   = w_b_mod[CHUNK-1:0];
      assign w_ci     = w_cin0;
      assign w_vld_in = in_valid;
      assign w_sum_in = w_s;
    end else begin : g_body
      assign w_op_a   = g_stg[k-1].g_skew.r_a_p[CHUNK-1:0];
      assign w_op_b   = g_stg[k-1].g_skew.r_b_p[CHUNK-1:0];
      assign w_ci     = g_stg[k-1].r_c_p;
      assign w_vld_in = g_stg[k-1].r_vld_p;
      assign w_sum_in = {w_s, g_stg[k-1].r_sum_p};
    end

    adder_slice #(
      .CHUNK (CHUNK)
    ) u_slice (
      .a     (w_op_a),
      .b     (w_op_b),
      .cin   (w_ci),
      .s     (w_s),
      .cout  (w_co),
      .c_msb (w_cm)
    );

    // Stage k: register slot valid, slice carry-out and the growing result word.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld_p <= 1'b0;
        r_sum_p <= '0;
        r_c_p   <= 1'b0;
      end else if (w_en) begin
        r_vld_p <= w_vld_in;
        r_sum_p <= w_sum_in;
        r_c_p   <= w_co;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [REMW-1:0] r_a_p;
      logic [REMW-1:0] r_b_p;
      logic [REMW-1:0] w_a_rem;
      logic [REMW-1:0] w_b_rem;
      logic            w_unused_cm;

      // Only the top slice's MSB carry matters; lower slices drop it.
      assign w_unused_cm = w_cm;

      if (k == 0) begin : g_src_in
        assign w_a_rem = a[WIDTH-1:CHUNK];
        assign w_b_rem = w_b_mod[WIDTH-1:CHUNK];
      end else begin : g_src_prev
        assign w_a_rem = g_stg[k-1].g_skew.r_a_p[WIDTH-k*CHUNK-1:CHUNK];
        assign w_b_rem = g_stg[k-1].g_skew.r_b_p[WIDTH-k*CHUNK-1:CHUNK];
      end

      // Skew chain: carry the not-yet-added upper operand bits forward one stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a_p <= '0;
          r_b_p <= '0;
        end else if (w_en) begin
          r_a_p <= w_a_rem;
          r_b_p <= w_b_rem;
        end
      end
    end else begin : g_tail
      logic r_cm_p;

      // Final stage: keep the carry into the word MSB for the overflow flag.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cm_p <= 1'b0;
        end else if (w_en) begin
          r_cm_p <= w_cm;
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].r_vld_p;
  assign sum       = g_stg[STAGES-1].r_sum_p;
  assign c_out     = g_stg[STAGES-1].r_c_p;
  assign ovf       = g_stg[STAGES-1].r_c_p ^ g_stg[STAGES-1].g_tail.r_cm_p;

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder (WIDTH=16, STAGES=4) with a queue-based
// arithmetic reference model.
`timescale 1ns/1ps
module tb_pipelined_adder;

  localparam int W   = 16;
  localparam int S   = 4;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } res_t;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          t;
  } exp_t;

  pipelined_adder #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain 17-bit arithmetic for sum/carry, signed range test for overflow.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb);
    res_t        r;
    logic [15:0] bp;
    logic        ce;
    logic [16:0] tot;
    int          sv;
    bp   = sb ? ~y : y;
    ce   = sb ? 1'b1 : ci;
    tot  = {1'b0, x} + {1'b0, bp} + {16'd0, ce};
    sv   = int'($signed(x)) + int'($signed(bp)) + (ce ? 1 : 0);
    r.s  = tot[15:0];
    r.co = tot[16];
    r.ov = (sv > 32767) || (sv < -32768);
    return r;
  endfunction

  // One clock cycle: drive inputs just after the rising edge, observe at the falling edge.
  task automatic cyc(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                     input logic ci, input logic sb, input logic ordy, input logic rr,
                     output logic acc, output logic emit, output logic ovld,
                     output logic ir, output logic [15:0] s, output logic co,
                     output logic ovv);
    @(posedge clk);
    #1;
    rst       = rr;
    in_valid  = v;
    a         = aa;
    b         = bb;
    c_in      = ci;
    sub       = sb;
    out_ready = ordy;
    @(negedge clk);
    ir   = in_ready;
    ovld = out_valid;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    s    = sum;
    co   = c_out;
    ovv  = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    n_tests++; if (c_out !== 1'b0) begin n_fail++; $display("FAIL reset_c_out got=%b exp=0", c_out); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ta [7];
    logic [15:0] tb [7];
    logic        tc [7];
    logic        ts [7];
    logic [15:0] es [7];
    logic        eco [7];
    logic        eov [7];
    logic acc, emit, ovld, ir, co, ov;
    logic [15:0] s;
    int lat;
    ta  = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h0005, 16'h8000, 16'h7FFF, 16'h0005};
    tb  = '{16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h0001, 16'h0003};
    tc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ts  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    es  = '{16'h1235, 16'h0000, 16'h0100, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h0002};
    eco = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    eov = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, ta[i], tb[i], tc[i], ts[i], 1'b1, 1'b0, acc, emit, ovld, ir, s, co, ov);
      n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL dir%0d_accept got=%b exp=1", i, acc); end
      lat = -1;
      for (int j = 1; j <= 10; j++) begin
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, acc, emit, ovld, ir, s, co, ov);
        if (emit) begin
          lat = j;
          break;
        end
      end
      n_tests++;
      if (lat < 0) begin
        n_fail++; $display("FAIL dir%0d_timeout no result within 10 cycles", i);
      end else begin
        if (lat !== LAT) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); end
        n_tests++; if (s !== es[i]) begin n_fail++; $display("FAIL dir%0d_sum got=%h exp=%h", i, s, es[i]); end
        n_tests++; if (co !== eco[i]) begin n_fail++; $display("FAIL dir%0d_c_out got=%b exp=%b", i, co, eco[i]); end
        n_tests++; if (ov !== eov[i]) begin n_fail++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ov, eov[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t e;
    res_t r;
    logic acc, emit, ovld, ir, co, ov, ordy, v;
    logic [15:0] s;
    int idx, got;
    idx = 1;
    got = 0;
    for (int n = 0; n < 40; n++) begin
      ordy = !(n >= 4 && n <= 6);
      v    = (idx <= 8);
      cyc(v, 16'(idx), 16'h0100, 1'b0, 1'b0, ordy, 1'b0, acc, emit, ovld, ir, s, co, ov);
      if (n >= 4 && n <= 6) begin
        n_tests++; if (ir !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_hold cyc=%0d got=%b exp=0", n, ir); end
        n_tests++;
        if (ovld !== 1'b1 || s !== 16'h0101) begin
          n_fail++; $display("FAIL bp_hold_stable cyc=%0d got valid=%b sum=%h exp valid=1 sum=0101", n, ovld, s);
        end
      end
      if (emit) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_unexpected cyc=%0d got sum=%h exp no result", n, s);
        end else begin
          e = q.pop_front();
          if (s !== e.s) begin n_fail++; $display("FAIL bp_order cyc=%0d got=%h exp=%h", n, s, e.s); end
          got++;
        end
      end
      if (acc) begin
        r = model(16'(idx), 16'h0100, 1'b0, 1'b0);
        e.s = r.s; e.co = r.co; e.ov = r.ov; e.t = n;
        q.push_back(e);
        idx++;
      end
    end
    n_tests++; if (got !== 8) begin n_fail++; $display("FAIL bp_count got=%0d exp=8", got); end
    n_tests++; if (q.size() !== 0) begin n_fail++; $display("FAIL bp_leftover got=%0d exp=0", q.size()); end
  endtask

  task automatic test_bubbles();
    exp_t q[$];
    exp_t e;
    res_t r;
    logic acc_at [32];
    logic acc, emit, ovld, ir, co, ov, v, ci, sb, expv;
    logic [15:0] s, aa, bb;
    int k;
    k = 0;
    for (int n = 0; n < 32; n++) acc_at[n] = 1'b0;
    for (int n = 0; n < 24; n++) begin
      v  = (n % 2 == 0) && (k < 6);
      aa = 16'($urandom);
      bb = 16'($urandom);
      ci = 1'($urandom);
      sb = 1'($urandom);
      cyc(v, aa, bb, ci, sb, 1'b1, 1'b0, acc, emit, ovld, ir, s, co, ov);
      expv = (n >= LAT) ? acc_at[n-LAT] : 1'b0;
      n_tests++; if (ovld !== expv) begin n_fail++; $display("FAIL bub_valid cyc=%0d got=%b exp=%b", n, ovld, expv); end
      if (emit && q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (s !== e.s || co !== e.co || ov !== e.ov || (n - e.t) !== LAT) begin
          n_fail++;
          $display("FAIL bub_result cyc=%0d got sum=%h co=%b ov=%b lat=%0d exp sum=%h co=%b ov=%b lat=%0d",
                   n, s, co, ov, n - e.t, e.s, e.co, e.ov, LAT);
        end
      end
      if (acc) begin
        acc_at[n] = 1'b1;
        r = model(aa, bb, ci, sb);
        e.s = r.s; e.co = r.co; e.ov = r.ov; e.t = n;
        q.push_back(e);
        k++;
      end
    end
    n_tests++; if (q.size() !== 0 || k !== 6) begin n_fail++; $display("FAIL bub_complete got left=%0d beats=%0d exp left=0 beats=6", q.size(), k); end
  endtask

  task automatic test_reset_midflight();
    logic acc, emit, ovld, ir, co, ov, expv;
    logic [15:0] s;
    for (int n = 0; n < 3; n++) begin
      cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, acc, emit, ovld, ir, s, co, ov);
    end
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, acc, emit, ovld, ir, s, co, ov);
    // First in-flight beat would be visible now; reset lands in this same cycle.
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, acc, emit, ovld, ir, s, co, ov);
    n_tests++; if (ovld !== 1'b0) begin n_fail++; $display("FAIL rst_mid_immediate got=%b exp=0", ovld); end
    cyc(1'b1, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, acc, emit, ovld, ir, s, co, ov);
    n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL rst_mid_accept got=%b exp=1", acc); end
    n_tests++; if (ovld !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale cyc=0 got=%b exp=0", ovld); end
    for (int j = 1; j <= 10; j++) begin
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, acc, emit, ovld, ir, s, co, ov);
      expv = (j == LAT);
      n_tests++; if (ovld !== expv) begin n_fail++; $display("FAIL rst_mid_valid cyc=%0d got=%b exp=%b", j, ovld, expv); end
      if (j == LAT) begin
        n_tests++; if (s !== 16'h0005) begin n_fail++; $display("FAIL rst_mid_sum got=%h exp=0005", s); end
      end
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    res_t r;
    logic acc, emit, ovld, ir, co, ov, v, ci, sb, ordy;
    logic [15:0] s, aa, bb;
    logic prev_stall, p_co, p_ov;
    logic [15:0] p_s;
    logic [15:0] corners [4];
    corners = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000};
    prev_stall = 1'b0;
    p_s = '0; p_co = 1'b0; p_ov = 1'b0;
    for (int n = 0; n < 340; n++) begin
      if (n < 300) begin
        v    = ($urandom_range(0, 9) < 7);
        ordy = ($urandom_range(0, 3) != 0);
      end else begin
        v    = 1'b0;
        ordy = 1'b1;
      end
      aa = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      bb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      ci = 1'($urandom);
      sb = 1'($urandom);
      cyc(v, aa, bb, ci, sb, ordy, 1'b0, acc, emit, ovld, ir, s, co, ov);
      n_tests++;
      if (ir !== (!ovld || ordy)) begin
        n_fail++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", n, ir, (!ovld || ordy));
      end
      if (prev_stall) begin
        n_tests++;
        if (ovld !== 1'b1 || s !== p_s || co !== p_co || ov !== p_ov) begin
          n_fail++; $display("FAIL rnd_stall_stable cyc=%0d got v=%b sum=%h exp v=1 sum=%h", n, ovld, s, p_s);
        end
      end
      if (emit) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_unexpected cyc=%0d got sum=%h exp no result", n, s);
        end else begin
          e = q.pop_front();
          if (s !== e.s || co !== e.co || ov !== e.ov) begin
            n_fail++;
            $display("FAIL rnd_result cyc=%0d got sum=%h co=%b ov=%b exp sum=%h co=%b ov=%b",
                     n, s, co, ov, e.s, e.co, e.ov);
          end
        end
      end
      if (acc) begin
        r = model(aa, bb, ci, sb);
        e.s = r.s; e.co = r.co; e.ov = r.ov; e.t = n;
        q.push_back(e);
      end
      prev_stall = ovld && !ordy;
      p_s = s; p_co = co; p_ov = ov;
    end
    n_tests++; if (q.size() !== 0) begin n_fail++; $display("FAIL rnd_drain got left=%0d exp=0", q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_bubbles();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
